// File: rtl/isp_ccm_frame.sv
// isp_ccm_frame: 3x3 signed colour-correction matrix with offsets, rounding and
// saturation; staging bank committed atomically at frame start; bypass mode.
//
// Ports:
//   pclk, rst            pixel clock, synchronous active-high reset
//   cfg_we/addr/wdata    staging bank write (0..8 matrix, 9..11 offsets, 12 bypass)
//   cfg_commit           request to load staging into active at next frame start
//   cfg_pending          commit requested, not yet applied
//   in_href/in_vsync     line valid / frame sync, in_r/g/b input pixel
//   out_href/out_vsync   inputs delayed 4 cycles, out_r/g/b corrected pixel
module isp_ccm_frame #(
    parameter int BITS      = 8,
    parameter int COEF_BITS = 12,
    parameter int COEF_FRAC = 8
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [COEF_BITS-1:0] cfg_wdata,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic [BITS-1:0]      in_r,
    input  logic [BITS-1:0]      in_g,
    input  logic [BITS-1:0]      in_b,
    output logic                 out_href,
    output logic                 out_vsync,
    output logic [BITS-1:0]      out_r,
    output logic [BITS-1:0]      out_g,
    output logic [BITS-1:0]      out_b
);

    localparam int OW = BITS + 1;
    localparam int PW = BITS + COEF_BITS + 1;
    localparam int SW = PW + 2;
    localparam int AW = SW + 1;

    localparam logic signed [COEF_BITS-1:0] ONE  = COEF_BITS'(1) << COEF_FRAC;
    localparam logic signed [SW-1:0]        RND  = SW'(1) << (COEF_FRAC - 1);
    localparam logic signed [AW-1:0]        MAXV = AW'((1 << BITS) - 1);

    // ---------------------------------------------------------------------
    // Register banks
    // ---------------------------------------------------------------------
    logic signed [COEF_BITS-1:0] stg_m [9];
    logic signed [COEF_BITS-1:0] act_m [9];
    logic signed [OW-1:0]        stg_o [3];
    logic signed [OW-1:0]        act_o [3];
    logic                        stg_byp;
    logic                        act_byp;

    logic vs_prev;
    logic frame_start;
    logic load;

    assign frame_start = in_vsync & ~vs_prev;
    // Only a commit registered before this cycle can load; a coincident
    // commit waits for the next frame start.
    assign load        = frame_start & cfg_pending;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_prev     <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            vs_prev     <= in_vsync;
            cfg_pending <= cfg_commit | (cfg_pending & ~frame_start);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                stg_m[i] <= (i % 4 == 0) ? ONE : '0;
                act_m[i] <= (i % 4 == 0) ? ONE : '0;
            end
            for (int i = 0; i < 3; i++) begin
                stg_o[i] <= '0;
                act_o[i] <= '0;
            end
            stg_byp <= 1'b0;
            act_byp <= 1'b0;
        end else begin
            // Active takes the pre-write staging contents, so a write in
            // the load cycle stays in staging only.
            if (load) begin
                act_m   <= stg_m;
                act_o   <= stg_o;
                act_byp <= stg_byp;
            end
            if (cfg_we) begin
                for (int i = 0; i < 9; i++) begin
                    if (cfg_addr == 4'(i)) stg_m[i] <= cfg_wdata;
                end
                for (int i = 0; i < 3; i++) begin
                    if (cfg_addr == 4'(i + 9)) stg_o[i] <= cfg_wdata[OW-1:0];
                end
                if (cfg_addr == 4'd12) stg_byp <= cfg_wdata[0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline
    // ---------------------------------------------------------------------
    logic [3:0]           h_sr;
    logic [3:0]           v_sr;

    logic [BITS-1:0]      s1_pix [3];

    logic signed [PW-1:0] prod   [9];
    logic signed [OW-1:0] s2_off [3];
    logic [BITS-1:0]      s2_raw [3];
    logic                 s2_byp;

    logic signed [SW-1:0] s3_val [3];
    logic signed [OW-1:0] s3_off [3];
    logic [BITS-1:0]      s3_raw [3];
    logic                 s3_byp;

    logic signed [OW-1:0] ext    [3];
    logic signed [SW-1:0] sum    [3];
    logic signed [SW-1:0] shr    [3];
    logic signed [AW-1:0] tot    [3];
    logic [BITS-1:0]      res    [3];

    assign out_href  = h_sr[3];
    assign out_vsync = v_sr[3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            ext[k] = $signed({1'b0, s1_pix[k]});
            sum[k] = SW'(prod[3*k]) + SW'(prod[3*k+1])
                   + SW'(prod[3*k+2]) + RND;
            shr[k] = sum[k] >>> COEF_FRAC;
            tot[k] = AW'(s3_val[k]) + AW'(s3_off[k]);
            if (tot[k] < 0) begin
                res[k] = '0;
            end else if (tot[k] > MAXV) begin
                res[k] = '1;
            end else begin
                res[k] = tot[k][BITS-1:0];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            h_sr   <= '0;
            v_sr   <= '0;
            s2_byp <= 1'b0;
            s3_byp <= 1'b0;
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
            for (int k = 0; k < 9; k++) prod[k] <= '0;
            for (int k = 0; k < 3; k++) begin
                s1_pix[k] <= '0;
                s2_off[k] <= '0;
                s2_raw[k] <= '0;
                s3_val[k] <= '0;
                s3_off[k] <= '0;
                s3_raw[k] <= '0;
            end
        end else begin
            h_sr <= {h_sr[2:0], in_href};
            v_sr <= {v_sr[2:0], in_vsync};

            // Stage 1: input register
            s1_pix[0] <= in_r;
            s1_pix[1] <= in_g;
            s1_pix[2] <= in_b;

            // Stage 2: multiplies; offsets and bypass travel with the
            // pixel so a bank load never touches pixels in flight.
            for (int k = 0; k < 9; k++) begin
                prod[k] <= PW'(ext[k % 3]) * PW'(act_m[k]);
            end
            for (int k = 0; k < 3; k++) begin
                s2_off[k] <= act_o[k];
                s2_raw[k] <= s1_pix[k];
            end
            s2_byp <= act_byp;

            // Stage 3: row sum, round, shift
            for (int k = 0; k < 3; k++) begin
                s3_val[k] <= shr[k];
                s3_off[k] <= s2_off[k];
                s3_raw[k] <= s2_raw[k];
            end
            s3_byp <= s2_byp;

            // Stage 4: offset, clamp, bypass mux, href gating
            if (!h_sr[2]) begin
                out_r <= '0;
                out_g <= '0;
                out_b <= '0;
            end else if (s3_byp) begin
                out_r <= s3_raw[0];
                out_g <= s3_raw[1];
                out_b <= s3_raw[2];
            end else begin
                out_r <= res[0];
                out_g <= res[1];
                out_b <= res[2];
            end
        end
    end

endmodule

// File: doc/isp_ccm_frame.md
# isp_ccm_frame

Parametrised colour-correction matrix for the ISP RGB pipeline, placed after demosaic/AWB and before gamma. It computes a 3x3 signed fixed-point matrix product with per-channel signed offsets, rounding and saturation. Coefficient width, fraction bits and pixel width are configurable. Software writes coefficients into a staging bank, and the bank is committed atomically at the next frame start, so a frame is never processed with a mixed matrix. A bypass mode passes pixels through with matching latency.

## Interface
- BITS, 8, pixel component width (unsigned).
- COEF_BITS, 12, signed coefficient width (two's complement).
- COEF_FRAC, 8, fraction bits of a coefficient; 1.0 = 1<<COEF_FRAC. Legal range is 1..COEF_BITS-2.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high. One clock domain (pclk); reset is synchronous and active-high.
- cfg_we  in  1  staging write strobe.
- cfg_addr  in  4  staging index:
  - 0..8: m_rr, m_rg, m_rb, m_gr, m_gg, m_gb, m_br, m_bg, m_bb.
  - 9..11: off_r, off_g, off_b.
  - 12: bypass (wdata[0]).
  - 13..15: ignored.
- cfg_wdata  in  COEF_BITS  write data. Offsets use the low BITS+1 bits, signed.
- cfg_commit  in  1  one-cycle request to apply the staging bank at the next frame start.
- cfg_pending  out  1  commit requested but not yet applied.
- in_href, in_vsync  in  1 each  line-valid and frame sync (vsync active-high).
- in_r, in_g, in_b  in  BITS each  input pixel.
- out_href, out_vsync  out  1 each  in_href/in_vsync delayed by 4 cycles.
- out_r, out_g, out_b  out  BITS each  corrected pixel; 0 whenever out_href=0.

## Operation
- **Banks.** There are two register banks, staging and active. Each holds 9 coefficients, 3 offsets and the bypass bit.
  - Reset value of both banks: identity, i.e. diagonal = 1<<COEF_FRAC, off-diagonal = 0, offsets = 0, bypass = 0.
- **Staging writes.**
  - cfg_we=1 writes cfg_wdata into staging[cfg_addr] on that edge.
  - Writes are accepted regardless of cfg_pending.
- **Commit.**
  - cfg_commit=1 sets cfg_pending on the next edge.
  - Frame start is the cycle where in_vsync=1 and its registered previous value was 0.
  - At frame start, if cfg_pending was already 1 on entry to that cycle: active <= staging and cfg_pending <= 0.
  - If cfg_commit and frame start coincide, the load is deferred to the following frame start and cfg_pending is set.
  - A cfg_we in the same cycle as a load is not included in that load; it stays in staging.
- **Datapath.** Inputs are zero-extended to BITS+1 signed.
  - Products are BITS+COEF_BITS+1 bits.
  - Row sums carry 2 extra guard bits.
  - Rounding: sum + (1<<(COEF_FRAC-1)), then arithmetic shift right by COEF_FRAC.
  - The signed offset is added, then the result is clamped: below 0 gives 0, above 2^BITS-1 gives 2^BITS-1.
- **Bypass.** When active bypass=1, out = in delayed 4 cycles with no arithmetic. href/vsync timing is identical.
- The active bank changes only at frame start, i.e. during vertical blanking. Pixels already in flight are unaffected.

## Timing
- Pipeline is 4 stages:
  1. Input register.
  2. Nine multiplies.
  3. Row sum, round and shift.
  4. Offset add, clamp, bypass mux.
- Latency: in_* at edge N appears on out_* after edge N+4. Throughput is 1 pixel per cycle with no stalls.
- out_href and out_vsync use a 4-deep shift register; the outputs are gated by out_href.
- Reset values:
  - Pipeline and shift registers: 0.
  - out_href, out_vsync, out_r/g/b, cfg_pending: 0.
  - The registered previous vsync value is 0, so vsync held high through reset release counts as a frame start on the first cycle after reset.
- Reset asserted mid-frame: all of the above return to their reset values on the next edge, banks return to identity, and any pending commit is dropped.

## Test plan
- **Reset identity:** release reset and stream in=(37,200,255) with href=1 → from cycle 4, out=(37,200,255); out=0 while href=0.
- **Matrix and saturation:** staging R row = 384, -64, -64 (1.5, -0.25, -0.25), G row = -256, 0, 0, B row identity. Commit, then pulse vsync.
  - in=(100,100,100) → out=(100,0,100).
  - in=(200,100,40) → R clamps to 255, out=(255,0,40).
- **Offsets and rounding:** identity matrix, off_r=-10, off_b=+20.
  - in=(5,50,250) → out=(0,50,255).
  - in=(50,50,50) → out=(40,50,70).
- **Frame-atomic update:** write a new matrix and commit mid-frame → output stays on the old matrix through the end of the frame; cfg_pending=1 until the next vsync rise; the new matrix is used from the first pixel of the next frame.
- **Commit coincident with vsync rise:** cfg_commit in the frame-start cycle → no load this frame, cfg_pending=1, load at the following frame start.
- **Bypass plus mid-frame reset:** bypass=1 → out equals in delayed 4 cycles. Assert rst for 1 cycle mid-line with a commit pending → outputs and cfg_pending are 0 next cycle, and the identity matrix is in effect afterwards.
